// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector:
// the FSM state enumeration and the default parameter values.
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } state_t;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_RST_PAT = 4'b1010;
    localparam int         DEF_CNT_W   = 8;
    localparam bit         DEF_RST_OVL = 1'b1;

endpackage

// File: rtl/seq_det_shreg.sv
// History shift register, fill counter and pattern comparator.
// The hit output is the compare against the post-shift history and fill,
// so the top level can register the match on the same edge that accepts the bit.
module seq_det_shreg
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             din,
    input  logic             ovl,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic             full_next,
    output logic             armed
);

    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_inc;

    // Post-shift history and saturating fill, and the hit compare on them
    always_comb begin
        hist_d    = {hist_q[PAT_W-2:0], din};
        fill_inc  = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        full_next = (fill_inc == FULL);
        hit       = shift && full_next && (hist_d == pattern);
    end

    // History and fill update; a non-overlapping hit restarts the fill but keeps history
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_d;
            fill_q <= (hit && !ovl) ? '0 : fill_inc;
        end
    end

    assign armed = (fill_q == FULL);

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial sequence detector with a loadable pattern,
// selectable overlap mode, Moore match flag and saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               CNT_W   = DEF_CNT_W,
    parameter bit               RST_OVL = DEF_RST_OVL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             pat_load,
    input  logic             ovl_in,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pattern_q;
    logic             ovl_q;
    logic             shift;
    logic             hit;
    logic             full_next;

    // A pattern load takes priority, so the bit offered on that edge is dropped
    assign shift = din_valid && !pat_load;

    seq_det_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (pat_load),
        .shift    (shift),
        .din      (din),
        .ovl      (ovl_q),
        .pattern  (pattern_q),
        .hit      (hit),
        .full_next(full_next),
        .armed    (armed)
    );

    // Pattern and overlap mode registers, reloaded by pat_load
    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= RST_PAT;
            ovl_q     <= RST_OVL;
        end else if (pat_load) begin
            pattern_q <= pat_in;
            ovl_q     <= ovl_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only accepted bits or a pattern load move the FSM
    always_comb begin
        state_d = state_q;
        if (pat_load) begin
            state_d = FILL;
        end else if (din_valid) begin
            if (hit) begin
                state_d = MATCH;
            end else if (full_next) begin
                state_d = ARMED;
            end else begin
                state_d = FILL;
            end
        end
    end

    assign dout = (state_q == MATCH);

    // Saturating match counter; a clear beats a coincident hit
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;

    // Channel A drives a default instance and a CNT_W=2 instance in parallel
    logic       din_a, dv_a, load_a, ovl_a, clr_a;
    logic [3:0] pat_in_a;
    logic       dout_a, armed_a, dout_b, armed_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    // Channel C drives an 8-bit pattern instance
    logic       din_c, dv_c, load_c, ovl_c, clr_c;
    logic [7:0] pat_in_c;
    logic       dout_c, armed_c;
    logic [7:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, index 0 = channel A, index 1 = channel C
    int m_w[2];
    int m_rstpat[2];
    int m_hist[2];
    int m_fill[2];
    int m_pat[2];
    int m_ovl[2];
    int m_last[2];
    int m_cnt[2];
    int m_cnt2;

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .pat_in(pat_in_a),
        .pat_load(load_a), .ovl_in(ovl_a), .cnt_clr(clr_a),
        .dout(dout_a), .match_cnt(cnt_a), .armed(armed_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .pat_in(pat_in_a),
        .pat_load(load_a), .ovl_in(ovl_a), .cnt_clr(clr_a),
        .dout(dout_b), .match_cnt(cnt_b), .armed(armed_b)
    );

    seq_detect_param #(.PAT_W(8), .RST_PAT(8'hA5), .CNT_W(8), .RST_OVL(1'b1)) dut_c (
        .clk(clk), .rst(rst), .din(din_c), .din_valid(dv_c), .pat_in(pat_in_c),
        .pat_load(load_c), .ovl_in(ovl_c), .cnt_clr(clr_c),
        .dout(dout_c), .match_cnt(cnt_c), .armed(armed_c)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic modelReset(input int ch);
        m_hist[ch] = 0;
        m_fill[ch] = 0;
        m_pat[ch]  = m_rstpat[ch];
        m_ovl[ch]  = 1;
        m_last[ch] = 0;
        m_cnt[ch]  = 0;
        if (ch == 0) m_cnt2 = 0;
    endtask

    // Accept one bit: the newest PAT_W bits form the window, a full matching window is a hit
    task automatic modelBit(input int ch, input bit b);
        int mask;
        mask = (1 << m_w[ch]) - 1;
        m_hist[ch] = ((m_hist[ch] << 1) | int'(b)) & mask;
        if (m_fill[ch] < m_w[ch]) m_fill[ch]++;
        m_last[ch] = (m_fill[ch] == m_w[ch] && m_hist[ch] == m_pat[ch]) ? 1 : 0;
        if (m_last[ch] == 1 && m_ovl[ch] == 0) m_fill[ch] = 0;
    endtask

    task automatic modelEdge(input int ch, input bit load, input int pat, input bit ovl,
                             input bit dv, input bit b, input bit clr);
        bit hit;
        hit = 1'b0;
        if (!rst) begin
            modelReset(ch);
        end else begin
            if (load) begin
                m_pat[ch]  = pat;
                m_ovl[ch]  = int'(ovl);
                m_hist[ch] = 0;
                m_fill[ch] = 0;
                m_last[ch] = 0;
            end else if (dv) begin
                modelBit(ch, b);
                hit = (m_last[ch] == 1);
            end
            if (clr) begin
                m_cnt[ch] = 0;
                if (ch == 0) m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt[ch] < 255) m_cnt[ch]++;
                if (ch == 0 && m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic checkOutput();
        check("dout_a",  dout_a,  m_last[0]);
        check("armed_a", armed_a, (m_fill[0] == 4) ? 1 : 0);
        check("cnt_a",   cnt_a,   m_cnt[0]);
        check("dout_b",  dout_b,  m_last[0]);
        check("cnt_b",   cnt_b,   m_cnt2);
        check("dout_c",  dout_c,  m_last[1]);
        check("armed_c", armed_c, (m_fill[1] == 8) ? 1 : 0);
        check("cnt_c",   cnt_c,   m_cnt[1]);
    endtask

    // One clock edge: advance DUTs and model with the inputs currently driven, then compare
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        modelEdge(0, load_a, int'(pat_in_a), ovl_a, dv_a, din_a, clr_a);
        modelEdge(1, load_c, int'(pat_in_c), ovl_c, dv_c, din_c, clr_c);
        checkOutput();
    endtask

    task automatic sendA(input bit b);
        dv_a = 1'b1; din_a = b;
        applyStimulus();
        dv_a = 1'b0;
    endtask

    task automatic sendC(input bit b);
        dv_c = 1'b1; din_c = b;
        applyStimulus();
        dv_c = 1'b0;
    endtask

    task automatic loadA(input logic [3:0] pat, input bit ovl);
        load_a = 1'b1; pat_in_a = pat; ovl_a = ovl;
        applyStimulus();
        load_a = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        m_w[0] = 4; m_rstpat[0] = 4'b1010;
        m_w[1] = 8; m_rstpat[1] = 8'hA5;
        modelReset(0);
        modelReset(1);
        rst = 1'b0;
        din_a = 0; dv_a = 0; load_a = 0; ovl_a = 0; clr_a = 0; pat_in_a = '0;
        din_c = 0; dv_c = 0; load_c = 0; ovl_c = 0; clr_c = 0; pat_in_c = '0;

        // Reset state
        idle(2);
        check("rst_dout",  dout_a,  0);
        check("rst_armed", armed_a, 0);
        check("rst_cnt",   cnt_a,   0);
        rst = 1'b1;
        idle(1);

        // Bits 1,0,1,0: match visible in the cycle after the fourth bit
        sendA(1); sendA(0); sendA(1);
        check("b3_dout", dout_a, 0);
        sendA(0);
        check("b4_dout",  dout_a,  1);
        check("b4_cnt",   cnt_a,   1);
        check("b4_armed", armed_a, 1);

        // Overlapping continuation 1,0 gives the second hit
        sendA(1);
        check("b5_dout", dout_a, 0);
        sendA(0);
        check("b6_dout", dout_a, 1);
        check("b6_cnt",  cnt_a,  2);

        // Non-overlapping: 101010 gives one hit only
        loadA(4'b1010, 1'b0);
        sendA(1); sendA(0); sendA(1); sendA(0);
        check("novl_b4_dout",  dout_a,  1);
        check("novl_b4_armed", armed_a, 0);
        sendA(1);
        check("novl_b5_dout", dout_a, 0);
        sendA(0);
        check("novl_b6_cnt", cnt_a, 3);

        // Non-overlapping 1010,1010 gives hits after bits 4 and 8
        loadA(4'b1010, 1'b0);
        for (int i = 0; i < 8; i++) sendA(i[0] ? 1'b0 : 1'b1);
        check("novl8_dout", dout_a, 1);
        check("novl8_cnt",  cnt_a,  5);
        check("sat_cnt_b",  cnt_b,  3);

        // Gap in din_valid between bits 3 and 4, and dout held afterwards
        loadA(4'b1010, 1'b1);
        sendA(1); sendA(0); sendA(1);
        idle(3);
        check("gap_dout", dout_a, 0);
        sendA(0);
        check("gap_hit", dout_a, 1);
        idle(2);
        check("gap_hold", dout_a, 1);
        check("gap_cnt",  cnt_a,  6);

        // Clear coincident with a hit wins
        loadA(4'b1010, 1'b1);
        sendA(1); sendA(0); sendA(1);
        clr_a = 1'b1;
        sendA(0);
        clr_a = 1'b0;
        check("clr_hit_dout",  dout_a, 1);
        check("clr_hit_cnt_a", cnt_a,  0);
        check("clr_hit_cnt_b", cnt_b,  0);

        // Reset aborts a partial pattern
        loadA(4'b1010, 1'b1);
        sendA(1); sendA(0); sendA(1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        sendA(0);
        check("rstmid_dout",  dout_a,  0);
        check("rstmid_armed", armed_a, 0);

        // Load coincident with the completing bit discards that bit
        sendA(1); sendA(0); sendA(1);
        load_a = 1'b1; pat_in_a = 4'b1010; ovl_a = 1'b1;
        sendA(0);
        load_a = 1'b0;
        check("ldhit_dout",  dout_a,  0);
        check("ldhit_armed", armed_a, 0);
        check("ldhit_cnt",   cnt_a,   0);

        // 8-bit pattern A5
        sendC(1); sendC(0); sendC(1); sendC(0); sendC(0); sendC(1); sendC(0);
        check("c_b7_armed", armed_c, 0);
        sendC(1);
        check("c_b8_armed", armed_c, 1);
        check("c_b8_dout",  dout_c,  1);
        check("c_b8_cnt",   cnt_c,   1);
        sendC(0);
        check("c_b9_armed", armed_c, 1);
        check("c_b9_dout",  dout_c,  0);

        // Randomized phase on both channels
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) != 0);
            load_a   = ($urandom_range(0, 31) == 0);
            pat_in_a = 4'($urandom);
            ovl_a    = 1'($urandom);
            dv_a     = ($urandom_range(0, 3) != 0);
            din_a    = 1'($urandom);
            clr_a    = ($urandom_range(0, 31) == 0);
            load_c   = ($urandom_range(0, 63) == 0);
            pat_in_c = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
            ovl_c    = 1'($urandom);
            dv_c     = ($urandom_range(0, 3) != 0);
            din_c    = 1'($urandom);
            clr_c    = ($urandom_range(0, 63) == 0);
            applyStimulus();
        end
        rst = 1'b1; load_a = 0; dv_a = 0; clr_a = 0; load_c = 0; dv_c = 0; clr_c = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
